// File: rtl/alu_muldiv.sv
// Single-issue ALU with iterative RV32M-style multiply/divide.
// Base ops finish in one cycle; MUL/DIV iterate one bit per cycle over operand magnitudes.
module alu_muldiv #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_md,
   input  logic [3:0]      alu_control,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] inp1,
   input  logic [XLEN-1:0] inp2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic accept;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign result    = result_q;

   // Base ALU, evaluated directly on the request operands.
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    alu_res;

   assign shamt = inp2[SHAMT_W-1:0];

   always_comb begin
      // NOTE: every branch assigns alu_res; the default arm guarantees no latch.
      case (alu_control)
         4'b0000: alu_res = inp1 & inp2;
         4'b0001: alu_res = inp1 << shamt;
         4'b0010: alu_res = inp1 + inp2;
         4'b0011: alu_res = inp1 | inp2;
         4'b0100: alu_res = inp1 - inp2;
         4'b0101: alu_res = {{(XLEN-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
         4'b0110: alu_res = inp1 ^ inp2;
         4'b0111: alu_res = {{(XLEN-1){1'b0}}, (inp1 < inp2)};
         4'b1000: alu_res = inp1 >> shamt;
         4'b1001: alu_res = XLEN'($signed(inp1) >>> shamt);
         default: alu_res = inp1;
      endcase
   end

   // Operand signedness per funct3: MULH/MULHSU sign inp1, MULH signs inp2, DIV/REM sign both.
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf;

   assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]);
   assign b_signed = funct3[2] ? ~funct3[0] : (funct3 == 3'd1);
   assign a_neg    = a_signed && inp1[XLEN-1];
   assign b_neg    = b_signed && inp2[XLEN-1];
   assign mag_a    = a_neg ? -inp1 : inp1;
   assign mag_b    = b_neg ? -inp2 : inp2;
   assign div_zero = (inp2 == '0);
   assign div_ovf  = a_signed && (inp1 == MOST_NEG) && (inp2 == '1);

   // Shift-add step: acc holds {partial product, remaining multiplier bits}.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, mul_prod;
   logic [XLEN-1:0]   mul_res;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   assign mul_prod = neg_q ? -mul_next : mul_next;
   assign mul_res  = (f3_q[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

   // Restoring step: acc holds {partial remainder, dividend bits / quotient bits}.
   logic [XLEN:0]     div_trial;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff, div_sel, div_res;
   logic [2*XLEN-1:0] div_next;

   assign div_trial = acc_q[2*XLEN-1:XLEN-1];
   assign div_ge    = (div_trial >= {1'b0, opnd_q});
   assign div_diff  = div_trial[XLEN-1:0] - opnd_q;
   assign div_next  = {(div_ge ? div_diff : div_trial[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
   assign div_sel   = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
   assign div_res   = neg_q ? -div_sel : div_sel;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      result_d = result_q;

      case (state_q)
         ST_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(XLEN)) begin
               state_d  = ST_DONE;
               result_d = mul_res;
            end
         end
         ST_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(XLEN)) begin
               state_d  = ST_DONE;
               result_d = div_res;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: ;
      endcase

      // Accept is only possible in IDLE or a draining DONE, so it overrides the above.
      if (accept) begin
         cnt_d = '0;
         f3_d  = funct3;
         if (!is_md) begin
            state_d  = ST_DONE;
            result_d = alu_res;
         end else if (!funct3[2]) begin
            state_d = ST_MUL;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            opnd_d  = mag_a;
            neg_d   = a_neg ^ b_neg;
         end else if (div_zero) begin
            state_d  = ST_DONE;
            result_d = funct3[1] ? inp1 : '1;
         end else if (div_ovf) begin
            state_d  = ST_DONE;
            result_d = funct3[1] ? '0 : inp1;
         end else begin
            state_d = ST_DIV;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            opnd_d  = mag_b;
            neg_d   = funct3[1] ? a_neg : (a_neg ^ b_neg);
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: base ops, M ops, short-circuits, backpressure, mid-op reset,
// plus a 16-bit instance for the narrow multiply.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        is_md = 1'b0;
   logic [3:0]  alu_control = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] inp1 = '0;
   logic [31:0] inp2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   logic        in_valid16 = 1'b0;
   logic        in_ready16;
   logic        is_md16 = 1'b0;
   logic [3:0]  alu_control16 = '0;
   logic [2:0]  funct3_16 = '0;
   logic [15:0] inp1_16 = '0;
   logic [15:0] inp2_16 = '0;
   logic        out_valid16;
   logic        out_ready16 = 1'b0;
   logic [15:0] result16;
   logic        busy16;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_muldiv #(.XLEN(32)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .is_md(is_md), .alu_control(alu_control), .funct3(funct3),
      .inp1(inp1), .inp2(inp2),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   alu_muldiv #(.XLEN(16)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .is_md(is_md16), .alu_control(alu_control16), .funct3(funct3_16),
      .inp1(inp1_16), .inp2(inp2_16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .busy(busy16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request from IDLE, wait for the result, check value/latency/busy, then drain.
   task automatic run_op(input string tag, input logic md, input logic [3:0] ctl,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int busy_cnt;
      is_md = md; alu_control = ctl; funct3 = f3; inp1 = a; inp2 = b;
      in_valid = 1'b1;
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      inp1 = 32'hDEAD_BEEF; inp2 = 32'h1234_5678;
      lat = 1;
      busy_cnt = 0;
      while (!out_valid && lat < 100) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " result"}, 64'(result), 64'(exp_res));
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic seen_valid;
      int   lat16;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset result", 64'(result), 64'd0);
      rst = 1'b0;
      check("in_ready after reset", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Base ops, latency 1
      run_op("SUB 5-7",     1'b0, 4'b0100, 3'd0, 32'd5,          32'd7,          32'hFFFF_FFFE, 1);
      run_op("SRA 0x21",    1'b0, 4'b1001, 3'd0, 32'h8000_0000,  32'h0000_0021,  32'hC000_0000, 1);
      run_op("ADD wrap",    1'b0, 4'b0010, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1);
      run_op("SLT -1<1",    1'b0, 4'b0101, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd1,         1);
      run_op("SLTU max<1",  1'b0, 4'b0111, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,         1);
      run_op("SLL 31",      1'b0, 4'b0001, 3'd0, 32'd1,          32'hFFFF_FFFF,  32'h8000_0000, 1);
      run_op("SRL 4",       1'b0, 4'b1000, 3'd0, 32'h8000_0000,  32'd4,          32'h0800_0000, 1);
      run_op("AND",         1'b0, 4'b0000, 3'd0, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234, 1);
      run_op("OR",          1'b0, 4'b0011, 3'd0, 32'hF000_0001,  32'h0000_0F00,  32'hF000_0F01, 1);
      run_op("XOR",         1'b0, 4'b0110, 3'd0, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555, 1);
      run_op("pass 1111",   1'b0, 4'b1111, 3'd0, 32'h1357_9BDF,  32'h2468_ACE0,  32'h1357_9BDF, 1);

      // Multiply, latency 33
      run_op("MULH -1*-1",  1'b1, 4'b0000, 3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 33);
      run_op("MULHU max^2", 1'b1, 4'b0000, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
      run_op("MUL 7*-3",    1'b1, 4'b0000, 3'd0, 32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB, 33);
      run_op("MULHSU -1*u", 1'b1, 4'b0000, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33);

      // Divide, latency 33, and latency-1 short-circuits
      run_op("DIV -7/2",    1'b1, 4'b0000, 3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33);
      run_op("REM -7/2",    1'b1, 4'b0000, 3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33);
      run_op("DIVU 100/7",  1'b1, 4'b0000, 3'd5, 32'd100,        32'd7,          32'd14,        33);
      run_op("REMU 100/7",  1'b1, 4'b0000, 3'd7, 32'd100,        32'd7,          32'd2,         33);
      run_op("DIVU 7/0",    1'b1, 4'b0000, 3'd5, 32'd7,          32'd0,          32'hFFFF_FFFF, 1);
      run_op("REMU 7/0",    1'b1, 4'b0000, 3'd7, 32'd7,          32'd0,          32'd7,         1);
      run_op("REM ovf",     1'b1, 4'b0000, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1);
      run_op("DIV ovf",     1'b1, 4'b0000, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);

      // Backpressure: hold result in DONE, then drain and accept in the same cycle
      is_md = 1'b0; alu_control = 4'b0010; inp1 = 32'd3; inp2 = 32'd4;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp first out_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp hold result", 64'(result), 64'd7);
         check("bp hold out_valid", 64'(out_valid), 64'd1);
         check("bp hold in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      alu_control = 4'b0110; inp1 = 32'h0000_F0F0; inp2 = 32'h0000_0FF0;
      in_valid = 1'b1;
      #1;
      check("bp drain in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("bp new out_valid", 64'(out_valid), 64'd1);
      check("bp new result", 64'(result), 64'h0000_FF00);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp idle after drain", 64'(out_valid), 64'd0);

      // Reset in the middle of a DIVU
      is_md = 1'b1; funct3 = 3'd5; inp1 = 32'hFFFF_FFFF; inp2 = 32'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("mid-op busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("async rst busy", 64'(busy), 64'd0);
      check("async rst out_valid", 64'(out_valid), 64'd0);
      check("async rst result", 64'(result), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("in_ready after mid-op reset", 64'(in_ready), 64'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen_valid = 1'b1;
         @(posedge clk); #1;
      end
      check("aborted op no result", 64'(seen_valid), 64'd0);
      run_op("ADD 1+1",     1'b0, 4'b0010, 3'd0, 32'd1,          32'd1,          32'd2,         1);

      // 16-bit build: MUL 0x00FF * 0x0101, latency 17
      is_md16 = 1'b1; funct3_16 = 3'd0; inp1_16 = 16'h00FF; inp2_16 = 16'h0101;
      in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      lat16 = 1;
      while (!out_valid16 && lat16 < 100) begin
         @(posedge clk); #1;
         lat16++;
      end
      check("x16 MUL result", 64'(result16), 64'hFFFF);
      check("x16 MUL latency", 64'(lat16), 64'd17);
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
      check("x16 idle after drain", 64'(out_valid16), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
